// File: rtl/mac_pkg.sv
// Shared types and helpers for the lane-serial multiply-accumulate block.
// Helper functions work on fixed maximum widths; callers cast down to their own sizes.
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_e;

  localparam int MAX_W      = 64;
  localparam int MAX_LANE_W = 32;
  localparam int MAX_BUS_W  = 256;

  // Upper clamp bound for a w-bit accumulator, as a MAX_W-bit pattern.
  function automatic logic [MAX_W-1:0] sat_hi(input int w, input logic sgn);
    if (sgn) return (MAX_W'(1) << (w - 1)) - MAX_W'(1);
    return (MAX_W'(1) << w) - MAX_W'(1);
  endfunction

  // Lower clamp bound, two's-complement sign-extended to MAX_W bits.
  function automatic logic [MAX_W-1:0] sat_lo(input int w, input logic sgn);
    if (sgn) return ~((MAX_W'(1) << (w - 1)) - MAX_W'(1));
    return '0;
  endfunction

  // Lane 0 sits in the most-significant bits of the packed bus.
  function automatic logic [MAX_LANE_W-1:0] lane_extract(
    input logic [MAX_BUS_W-1:0] bus,
    input int                   n_lanes,
    input int                   lw,
    input int                   idx
  );
    logic [MAX_BUS_W-1:0] sh;
    logic [MAX_BUS_W-1:0] mask;
    sh   = bus >> ((n_lanes - 1 - idx) * lw);
    mask = (MAX_BUS_W'(1) << lw) - MAX_BUS_W'(1);
    return MAX_LANE_W'(sh & mask);
  endfunction

endpackage

// File: rtl/mac_lane_mult.sv
// Single-lane multiplier, signed or unsigned by select; the natural place to add a pipeline stage.
module mac_lane_mult #(
  parameter int LANE_WIDTH = 8
) (
  input  logic [LANE_WIDTH-1:0]   a_i,
  input  logic [LANE_WIDTH-1:0]   b_i,
  input  logic                    signed_i,
  output logic [2*LANE_WIDTH-1:0] prod_o
);

  localparam int PROD_W = 2 * LANE_WIDTH;

  logic [PROD_W-1:0] a_w;
  logic [PROD_W-1:0] b_w;

  // Extending to the full product width first makes the truncated product exact in both modes.
  assign a_w    = {{LANE_WIDTH{signed_i & a_i[LANE_WIDTH-1]}}, a_i};
  assign b_w    = {{LANE_WIDTH{signed_i & b_i[LANE_WIDTH-1]}}, b_i};
  assign prod_o = a_w * b_w;

endmodule

// File: rtl/mac_serial_acc.sv
// Lane-serial saturating dot-product accumulator: one lane per cycle, MSB lane first,
// result held on a valid/ready port after the beat flagged last.
module mac_serial_acc
  import mac_pkg::*;
#(
  parameter int NUM_LANES  = 3,
  parameter int LANE_WIDTH = 8,
  parameter int ACC_WIDTH  = 20
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_LANES*LANE_WIDTH-1:0] in_attr,
  input  logic [NUM_LANES*LANE_WIDTH-1:0] in_coeff,
  input  logic                            in_signed,
  input  logic                            in_last,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [ACC_WIDTH-1:0]            out_acc,
  output logic                            out_sat
);

  localparam int BUS_W  = NUM_LANES * LANE_WIDTH;
  localparam int PROD_W = 2 * LANE_WIDTH;
  localparam int SUM_W  = ACC_WIDTH + 1;
  localparam int IDX_W  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  localparam logic [SUM_W-1:0] HI_S = SUM_W'(sat_hi(ACC_WIDTH, 1'b1));
  localparam logic [SUM_W-1:0] LO_S = SUM_W'(sat_lo(ACC_WIDTH, 1'b1));
  localparam logic [SUM_W-1:0] HI_U = SUM_W'(sat_hi(ACC_WIDTH, 1'b0));

  state_e state_q, state_d;

  logic [BUS_W-1:0]      attr_q, attr_d;
  logic [BUS_W-1:0]      coeff_q, coeff_d;
  logic                  signed_q, signed_d;
  logic                  last_q, last_d;
  logic [IDX_W-1:0]      lane_idx_q, lane_idx_d;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic                  sat_q, sat_d;
  logic [ACC_WIDTH-1:0]  out_acc_q, out_acc_d;

  logic                  accept;
  logic                  mac_step;
  logic                  consume;
  logic                  last_lane;
  logic [LANE_WIDTH-1:0] lane_a;
  logic [LANE_WIDTH-1:0] lane_b;
  logic [PROD_W-1:0]     prod;
  logic [SUM_W-1:0]      prod_ext;
  logic [SUM_W-1:0]      acc_ext;
  logic [SUM_W-1:0]      sum;
  logic [ACC_WIDTH-1:0]  acc_next;
  logic                  sat_hit;

  assign last_lane = (lane_idx_q == IDX_W'(NUM_LANES - 1));

  assign lane_a = LANE_WIDTH'(lane_extract(MAX_BUS_W'(attr_q), NUM_LANES, LANE_WIDTH,
                                           int'(lane_idx_q)));
  assign lane_b = LANE_WIDTH'(lane_extract(MAX_BUS_W'(coeff_q), NUM_LANES, LANE_WIDTH,
                                           int'(lane_idx_q)));

  mac_lane_mult #(
    .LANE_WIDTH(LANE_WIDTH)
  ) u_mult (
    .a_i     (lane_a),
    .b_i     (lane_b),
    .signed_i(signed_q),
    .prod_o  (prod)
  );

  // The accumulator is re-interpreted under the current beat's signedness.
  assign prod_ext = {{(SUM_W - PROD_W){signed_q & prod[PROD_W-1]}}, prod};
  assign acc_ext  = {signed_q & acc_q[ACC_WIDTH-1], acc_q};
  assign sum      = acc_ext + prod_ext;

  always_comb begin
    acc_next = sum[ACC_WIDTH-1:0];
    sat_hit  = 1'b0;
    if (signed_q) begin
      if ($signed(sum) > $signed(HI_S)) begin
        acc_next = HI_S[ACC_WIDTH-1:0];
        sat_hit  = 1'b1;
      end else if ($signed(sum) < $signed(LO_S)) begin
        acc_next = LO_S[ACC_WIDTH-1:0];
        sat_hit  = 1'b1;
      end
    end else if (sum > HI_U) begin
      acc_next = HI_U[ACC_WIDTH-1:0];
      sat_hit  = 1'b1;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_valid)  state_d = MAC;
      MAC:  if (last_lane) state_d = last_q ? OUT : IDLE;
      OUT:  if (out_ready) state_d = IDLE;
      default:             state_d = IDLE;
    endcase
  end

  // FSM: outputs and datapath strobes
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    mac_step  = 1'b0;
    consume   = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = rst_n;
        accept   = in_valid;
      end
      MAC: mac_step = 1'b1;
      OUT: begin
        out_valid = 1'b1;
        consume   = out_ready;
      end
      default: ;
    endcase
  end

  always_comb begin
    attr_d     = attr_q;
    coeff_d    = coeff_q;
    signed_d   = signed_q;
    last_d     = last_q;
    lane_idx_d = lane_idx_q;
    acc_d      = acc_q;
    sat_d      = sat_q;
    out_acc_d  = out_acc_q;
    if (accept) begin
      attr_d     = in_attr;
      coeff_d    = in_coeff;
      signed_d   = in_signed;
      last_d     = in_last;
      lane_idx_d = '0;
    end
    if (mac_step) begin
      acc_d      = acc_next;
      sat_d      = sat_q | sat_hit;
      lane_idx_d = last_lane ? '0 : lane_idx_q + IDX_W'(1);
      if (last_lane && last_q) out_acc_d = acc_next;
    end
    if (consume) begin
      acc_d = '0;
      sat_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      attr_q     <= '0;
      coeff_q    <= '0;
      signed_q   <= 1'b0;
      last_q     <= 1'b0;
      lane_idx_q <= '0;
      acc_q      <= '0;
      sat_q      <= 1'b0;
      out_acc_q  <= '0;
    end else begin
      attr_q     <= attr_d;
      coeff_q    <= coeff_d;
      signed_q   <= signed_d;
      last_q     <= last_d;
      lane_idx_q <= lane_idx_d;
      acc_q      <= acc_d;
      sat_q      <= sat_d;
      out_acc_q  <= out_acc_d;
    end
  end

  assign out_acc = out_acc_q;
  assign out_sat = sat_q;

endmodule

// File: tb/tb_mac_serial_acc.sv
// Randomised and directed bench for mac_serial_acc against a transaction-level arithmetic model.
module tb_mac_serial_acc;

  localparam int NL = 3;
  localparam int LW = 8;
  localparam int AW = 20;
  localparam int BW = NL * LW;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b1;
  logic          in_valid  = 1'b0;
  logic          in_signed = 1'b0;
  logic          in_last   = 1'b0;
  logic          out_ready = 1'b0;
  logic [BW-1:0] in_attr   = '0;
  logic [BW-1:0] in_coeff  = '0;
  logic          in_ready;
  logic          out_valid;
  logic          out_sat;
  logic [AW-1:0] out_acc;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Model state: whole-beat results are computed at accept time, revealed after NL edges.
  bit     m_ready = 1'b1;
  bit     m_ov    = 1'b0;
  bit     m_osat  = 1'b0;
  bit     m_sat   = 1'b0;
  bit     m_last  = 1'b0;
  longint m_acc   = 0;
  longint m_oacc  = 0;
  int     m_busy  = 0;

  mac_serial_acc #(
    .NUM_LANES (NL),
    .LANE_WIDTH(LW),
    .ACC_WIDTH (AW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_attr  (in_attr),
    .in_coeff (in_coeff),
    .in_signed(in_signed),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_acc  (out_acc),
    .out_sat  (out_sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint lane_val(input logic [BW-1:0] bus, input int i, input bit sgn);
    logic [BW-1:0] sh;
    longint v;
    sh = bus >> ((NL - 1 - i) * LW);
    v  = longint'(sh[LW-1:0]);
    if (sgn && v >= (longint'(1) << (LW - 1))) v -= (longint'(1) << LW);
    return v;
  endfunction

  task automatic model_beat(input logic [BW-1:0] a, input logic [BW-1:0] c, input bit s);
    longint accv, sum, hi, lo;
    hi = s ? (longint'(1) << (AW - 1)) - 1 : (longint'(1) << AW) - 1;
    lo = s ? -(longint'(1) << (AW - 1)) : 0;
    for (int i = 0; i < NL; i++) begin
      accv = m_acc;
      if (s && accv >= (longint'(1) << (AW - 1))) accv -= (longint'(1) << AW);
      sum = accv + lane_val(a, i, s) * lane_val(c, i, s);
      if (sum > hi) begin
        sum   = hi;
        m_sat = 1'b1;
      end else if (sum < lo) begin
        sum   = lo;
        m_sat = 1'b1;
      end
      m_acc = sum & ((longint'(1) << AW) - 1);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ready = 1'b1;
      m_ov    = 1'b0;
      m_osat  = 1'b0;
      m_sat   = 1'b0;
      m_last  = 1'b0;
      m_acc   = 0;
      m_oacc  = 0;
      m_busy  = 0;
    end else if (m_ov) begin
      if (out_ready) begin
        m_ov    = 1'b0;
        m_acc   = 0;
        m_sat   = 1'b0;
        m_ready = 1'b1;
      end
    end else if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        if (m_last) begin
          m_ov   = 1'b1;
          m_oacc = m_acc;
          m_osat = m_sat;
        end else begin
          m_ready = 1'b1;
        end
      end
    end else if (in_valid) begin
      model_beat(in_attr, in_coeff, in_signed);
      m_last  = in_last;
      m_busy  = NL;
      m_ready = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", in_ready, rst_n && m_ready);
      check("out_valid", out_valid, m_ov);
      if (m_ov) begin
        check("out_acc", out_acc, m_oacc);
        check("out_sat", out_sat, m_osat);
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 50 && !(m_ready && !m_ov); i++) @(negedge clk);
    if (!(m_ready && !m_ov)) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_wait: block still busy after 50 cycles");
    end
  endtask

  task automatic send_beat(input logic [BW-1:0] a, input logic [BW-1:0] c,
                           input bit s, input bit l);
    wait_idle();
    in_valid  = 1'b1;
    in_attr   = a;
    in_coeff  = c;
    in_signed = s;
    in_last   = l;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_result();
    for (int i = 0; i < 50 && !m_ov; i++) @(negedge clk);
    if (!m_ov) begin
      n_checks++;
      n_fail++;
      $display("FAIL result_wait: no result after 50 cycles");
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_acc", out_acc, 0);
    check("rst_out_sat", out_sat, 0);

    // unsigned single beat, with exact latency
    send_beat(24'h010203, 24'h040506, 1'b0, 1'b1);
    for (int k = 0; k <= 3; k++) begin
      check("t1_latency", out_valid, k == 3);
      if (k < 3) @(negedge clk);
    end
    check("t1_acc", out_acc, 'h00020);
    check("t1_sat", out_sat, 0);
    consume();

    send_beat(24'hFF02FE, 24'h03FD04, 1'b1, 1'b1);
    wait_result();
    check("t2_acc", out_acc, 'hFFFEF);
    check("t2_sat", out_sat, 0);
    consume();

    send_beat(24'hFFFFFF, 24'hFFFFFF, 1'b0, 1'b0);
    send_beat(24'hFFFFFF, 24'hFFFFFF, 1'b0, 1'b1);
    wait_result();
    check("t3_acc", out_acc, 'h5F406);
    check("t3_sat", out_sat, 0);
    consume();

    for (int i = 0; i < 6; i++) send_beat(24'hFFFFFF, 24'hFFFFFF, 1'b0, i == 5);
    wait_result();
    check("t4_acc", out_acc, 'hFFFFF);
    check("t4_sat", out_sat, 1);

    // backpressure with ignored beats offered
    repeat (5) begin
      in_valid  = 1'b1;
      in_attr   = BW'($urandom);
      in_coeff  = BW'($urandom);
      in_signed = 1'b0;
      in_last   = 1'b1;
      check("bp_in_ready", in_ready, 0);
      check("bp_valid", out_valid, 1);
      check("bp_acc", out_acc, 'hFFFFF);
      check("bp_sat", out_sat, 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    consume();
    send_beat(24'h010203, 24'h040506, 1'b0, 1'b1);
    wait_result();
    check("bp_next_acc", out_acc, 'h00020);
    check("bp_next_sat", out_sat, 0);
    consume();

    // reset during lane 1
    send_beat(24'hFFFFFF, 24'hFFFFFF, 1'b1, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rmac_out_valid", out_valid, 0);
    check("rmac_out_acc", out_acc, 0);
    check("rmac_out_sat", out_sat, 0);
    check("rmac_in_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rmac_ready_after", in_ready, 1);
    send_beat(24'h010203, 24'h040506, 1'b0, 1'b1);
    wait_result();
    check("rmac_next_acc", out_acc, 'h00020);
    consume();

    for (int i = 0; i < 800; i++) begin
      in_valid  = $urandom_range(0, 1) == 1;
      in_attr   = BW'($urandom);
      in_coeff  = BW'($urandom);
      in_signed = $urandom_range(0, 1) == 1;
      in_last   = $urandom_range(0, 3) == 0;
      out_ready = $urandom_range(0, 3) != 0;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_serial_acc.md
Name: mac_serial_acc

Overview:
- Parametrised successor to the fixed 3x8-bit lane-serial MAC.
- Takes NUM_LANES packed operand lanes per beat (attribute x coefficient) and multiplies one lane per cycle, most-significant lane first.
- Accumulates across multiple beats until a beat flagged last, then presents the saturated dot product on a valid/ready output.
- Sits between the attribute/coefficient RAM readers and the BDD node-evaluation logic.

Parameters:
- NUM_LANES, 3, lanes per input beat (>=1)
- LANE_WIDTH, 8, bits per lane operand
- ACC_WIDTH, 20, accumulator/result width (>= 2*LANE_WIDTH)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- in_attr  in  NUM_LANES*LANE_WIDTH  attribute lanes; lane 0 = MSBs
- in_coeff  in  NUM_LANES*LANE_WIDTH  coefficient lanes; lane 0 = MSBs
- in_signed  in  1  1 = two's-complement lanes, 0 = unsigned; sampled per beat
- in_last  in  1  beat closes the current accumulation
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_acc  out  ACC_WIDTH  accumulated result (two's-complement when signed)
- out_sat  out  1  saturation occurred anywhere in this result

Behaviour:
- Reset (rst_n low, async): state IDLE; accumulator, out_acc, out_sat, out_valid, lane index all 0; operand registers 0. in_ready = 1 while rst_n is high and state is IDLE.
- States:
  - IDLE: in_ready=1. On in_valid, register attr, coeff, signed and last; lane_idx=0; go to MAC.
  - MAC: each cycle, acc_next = sat(acc + ext(attr[lane] * coeff[lane])); lane_idx++. After lane NUM_LANES-1: if last, go to OUT (out_acc=acc_next, out_valid=1); else go to IDLE and keep the accumulator.
  - OUT: hold out_acc, out_sat and out_valid stable. On out_ready, clear acc and out_sat, drop out_valid, go to IDLE.
- in_ready is 0 in MAC and OUT. There is no overlap of beats.
- Latency: out_valid rises NUM_LANES edges after the accepting edge of the last beat. Throughput is one beat per NUM_LANES+1 cycles.
- Arithmetic:
  - Product width is 2*LANE_WIDTH.
  - Signed mode: both lanes are sign-interpreted and the product is sign-extended to ACC_WIDTH+1.
  - Unsigned mode: zero-extended.
  - Sum is computed in ACC_WIDTH+1 bits, then clamped:
    - unsigned range [0, 2^ACC_WIDTH-1]
    - signed range [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]
  - Any clamp sets sticky out_sat until the result is consumed.
- Mixed in_signed within one accumulation: the per-beat flag governs that beat's extension; the clamp range follows the current beat's flag.
- in_valid while in_ready=0 is ignored (not queued). Inputs are don't-care when in_valid=0.
- out_ready asserted while out_valid=0 has no effect.
- Reset mid-MAC or mid-OUT discards the partial accumulation; no output is produced for the aborted sequence.

Decomposition:
- Shared package mac_pkg: state enum (IDLE, MAC, OUT); saturation-bound functions parametrised by width and signedness; lane-extract function.
- One sub-module: mac_lane_mult. Combinational LANE_WIDTH x LANE_WIDTH multiplier with signed/unsigned select, producing a 2*LANE_WIDTH result; it is the place to pipeline later.

Test Plan (NUM_LANES=3, LANE_WIDTH=8, ACC_WIDTH=20):
- Unsigned single beat: attr=0x010203, coeff=0x040506, last=1 -> out_valid 3 edges after accept; out_acc=0x00020; out_sat=0.
- Signed single beat: attr=0xFF02FE, coeff=0x03FD04, signed=1, last=1 -> out_acc=0xFFFEF (-17); out_sat=0.
- Multi-beat unsigned: two beats of 0xFFFFFF x 0xFFFFFF, last on the second -> out_acc=0x5F406 (390150). Six such beats -> out_acc=0xFFFFF, out_sat=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_acc, out_valid and out_sat stable; in_ready=0; beats offered are ignored. Release -> next single-beat result is independent of the previous one.
- Reset mid-MAC: drop rst_n during lane 1 of a beat -> all outputs 0 immediately; in_ready=1 after release; following beat 0x010203 x 0x040506 yields 0x00020.
